ex_stage_mdu: RTL and testbench

Parametrised execute stage for the 5-stage MIPS pipeline. It computes branch targets, performs operand forwarding and ALU operations, and selects the destination register. It adds an iterative multiply/divide unit (MDU) with architectural HI/LO registers. MULT/DIV instructions hold the pipeline through `ex_stall` while the MDU iterates.

---
 rtl/ex_stage_mdu.sv | 247 ++++++++++++++++++++++++
 tb/tb_ex_stage_mdu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_mdu.sv
// Execute stage with forwarding, ALU, branch target and an iterative multiply/divide unit.
// Optional macro MDU_EARLY_TERM_EN: multiplies stop once the remaining multiplier is zero.
module ex_stage_mdu #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_ex_valid,
    input  logic [XLEN-1:0]   pc_add4,
    input  logic [XLEN-1:0]   read_data1,
    input  logic [XLEN-1:0]   read_data2,
    input  logic [XLEN-1:0]   imm,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [5:0]        funct,
    input  logic [1:0]        alu_op,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [XLEN-1:0]   wb_result,
    input  logic [1:0]        forward_a,
    input  logic [1:0]        forward_b,
    output logic              zero,
    output logic [XLEN-1:0]   alu_result,
    output logic [XLEN-1:0]   store_data,
    output logic [XLEN-1:0]   branch_addr,
    output logic [REG_AW-1:0] reg_dest,
    output logic              ex_stall,
    output logic [XLEN-1:0]   hi,
    output logic [XLEN-1:0]   lo
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MTHI = 6'h11;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MTLO = 6'h13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mdu_state_t;

    mdu_state_t        state_q;
    logic [CW-1:0]     cnt_q;
    logic              div_q;
    logic              sa_q;
    logic              sb_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   dvsr_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;

    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b_fwd;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   alu_d;
    logic [XLEN-1:0]   sum;
    logic [XLEN-1:0]   diff;
    logic              slt;
    logic              sltu;

    always_comb begin
        case (forward_a)
            2'b01:   op_a = wb_result;
            2'b10:   op_a = mem_result;
            default: op_a = read_data1;
        endcase
        case (forward_b)
            2'b01:   op_b_fwd = wb_result;
            2'b10:   op_b_fwd = mem_result;
            default: op_b_fwd = read_data2;
        endcase
    end

    assign op_b        = alu_src ? imm : op_b_fwd;
    assign store_data  = op_b_fwd;
    assign branch_addr = pc_add4 + (imm << 2);
    assign reg_dest    = reg_dst ? rd : rt;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;
    assign slt  = $signed(op_a) < $signed(op_b);
    assign sltu = op_a < op_b;

    always_comb begin
        alu_d = '0;
        case (alu_op)
            2'b01: alu_d = diff;
            2'b10: begin
                case (funct)
                    6'h20, 6'h21: alu_d = sum;
                    6'h22, 6'h23: alu_d = diff;
                    6'h24:        alu_d = op_a & op_b;
                    6'h25:        alu_d = op_a | op_b;
                    6'h26:        alu_d = op_a ^ op_b;
                    6'h27:        alu_d = ~(op_a | op_b);
                    6'h2A:        alu_d = {{(XLEN-1){1'b0}}, slt};
                    6'h2B:        alu_d = {{(XLEN-1){1'b0}}, sltu};
                    F_MFHI:       alu_d = hi_q;
                    F_MFLO:       alu_d = lo_q;
                    default:      alu_d = '0;
                endcase
            end
            default: alu_d = sum;
        endcase
    end

    assign alu_result = alu_d;
    assign zero       = (alu_d == '0);

    // MDU operand preparation: funct 0x18..0x1B, bit0 = unsigned, bit1 = divide
    logic              is_rtype;
    logic              mdu_start;
    logic              start_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    assign is_rtype     = (alu_op == 2'b10);
    assign mdu_start    = id_ex_valid && is_rtype && (funct[5:2] == 4'b0110);
    assign start_signed = ~funct[0];
    assign a_neg        = start_signed & op_a[XLEN-1];
    assign b_neg        = start_signed & op_b_fwd[XLEN-1];
    assign a_mag        = a_neg ? (~op_a + 1'b1) : op_a;
    assign b_mag        = b_neg ? (~op_b_fwd + 1'b1) : op_b_fwd;

    assign ex_stall = ((state_q == S_IDLE) && mdu_start) || (state_q == S_BUSY);

    logic [2*XLEN-1:0] prod_d;
    logic [XLEN-1:0]   mplier_d;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_sub;
    logic              div_ok;
    logic [XLEN-1:0]   rem_d;
    logic [XLEN-1:0]   quo_d;
    logic              early_done;
    logic              last_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    assign prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign mplier_d = mplier_q >> 1;

    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign rem_sub   = rem_shift - {1'b0, dvsr_q};
    assign div_ok    = ~rem_sub[XLEN];
    assign rem_d     = div_ok ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
    assign quo_d     = {quo_q[XLEN-2:0], div_ok};

`ifdef MDU_EARLY_TERM_EN
    assign early_done = ~div_q && (mplier_d == '0);
`else
    assign early_done = 1'b0;
`endif

    assign last_step = (cnt_q == CW'(XLEN - 1)) || early_done;

    // Divide by zero leaves |dividend| in the remainder, so the sign fix-up restores the dividend
    assign prod_fix = (sa_q ^ sb_q) ? (~prod_d + 1'b1) : prod_d;
    assign quo_fix  = (dvsr_q == '0) ? '1 : ((sa_q ^ sb_q) ? (~quo_d + 1'b1) : quo_d);
    assign rem_fix  = sa_q ? (~rem_d + 1'b1) : rem_d;

    // state  | meaning
    // S_IDLE | no MDU op in flight; MTHI/MTLO write here, MULT/DIV launch here
    // S_BUSY | one multiply or divide step per cycle, pipeline held
    // S_DONE | result committed, instruction leaves EX this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mdu_start) begin
                        div_q    <= funct[1];
                        sa_q     <= a_neg;
                        sb_q     <= b_neg;
                        mcand_q  <= {{XLEN{1'b0}}, a_mag};
                        mplier_q <= b_mag;
                        prod_q   <= '0;
                        rem_q    <= '0;
                        quo_q    <= a_mag;
                        dvsr_q   <= b_mag;
                        cnt_q    <= '0;
                        state_q  <= S_BUSY;
                    end else if (id_ex_valid && is_rtype && (funct == F_MTHI)) begin
                        hi_q <= op_a;
                    end else if (id_ex_valid && is_rtype && (funct == F_MTLO)) begin
                        lo_q <= op_a;
                    end
                end
                S_BUSY: begin
                    if (div_q) begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                    end else begin
                        prod_q   <= prod_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_d;
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        if (div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*XLEN-1:XLEN];
                            lo_q <= prod_fix[XLEN-1:0];
                        end
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed-vector bench for ex_stage_mdu: ALU/forwarding, MDU latency and results, reset and bubbles.
module tb_ex_stage_mdu;

    logic        clk;
    logic        reset;
    logic        id_ex_valid;
    logic [31:0] pc_add4;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        reg_dst;
    logic [31:0] mem_result;
    logic [31:0] wb_result;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] branch_addr;
    logic [4:0]  reg_dest;
    logic        ex_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int vec_cnt = 0;
    int err_cnt = 0;

    ex_stage_mdu #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .id_ex_valid(id_ex_valid), .pc_add4(pc_add4),
        .read_data1(read_data1), .read_data2(read_data2), .imm(imm), .rt(rt), .rd(rd),
        .funct(funct), .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
        .mem_result(mem_result), .wb_result(wb_result), .forward_a(forward_a),
        .forward_b(forward_b), .zero(zero), .alu_result(alu_result), .store_data(store_data),
        .branch_addr(branch_addr), .reg_dest(reg_dest), .ex_stall(ex_stall), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MDU_EARLY_TERM_EN
    localparam int STALL_M7  = 4;   // multiplier 7 has bit-length 3
    localparam int STALL_M3  = 3;
    localparam int STALL_M0  = 2;
`else
    localparam int STALL_M7  = 33;
    localparam int STALL_M3  = 33;
    localparam int STALL_M0  = 33;
`endif
    localparam int STALL_FULL = 33;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one MDU instruction and holds it until it leaves EX; cyc = observed stall cycles.
    task automatic run_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           output int cyc);
        id_ex_valid = 1'b1;
        alu_op      = 2'b10;
        alu_src     = 1'b0;
        forward_a   = 2'b00;
        forward_b   = 2'b00;
        funct       = f;
        read_data1  = a;
        read_data2  = b;
        #1;
        cyc = 0;
        while (ex_stall === 1'b1 && cyc < 100) begin
            cyc++;
            next_cycle();
        end
        next_cycle();
        id_ex_valid = 1'b0;
        funct       = 6'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        id_ex_valid = 1'b0;
        repeat (3) next_cycle();
        reset = 1'b0;
        #1;
        vec_cnt++; if (ex_stall !== 1'b0) begin err_cnt++; $display("FAIL reset_stall: got %b expected 0", ex_stall); end
        vec_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        vec_cnt++; if (lo !== 32'h0) begin err_cnt++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    endtask

    logic [1:0]  t_op [0:13] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10,
                                 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0]  t_fn [0:13] = '{6'h00, 6'h00, 6'h00, 6'h20, 6'h23, 6'h24, 6'h25,
                                 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h2A, 6'h3F, 6'h21};
    logic [31:0] t_a  [0:13] = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd3, 32'hF0F0, 32'hF0F0,
                                 32'hF0F0, 32'hF0F0, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd3, 32'd5, 32'd1};
    logic [31:0] t_b  [0:13] = '{32'd8, 32'd8, 32'd2, 32'd1, 32'd5, 32'h0FF0, 32'h0FF0,
                                 32'h0FF0, 32'h0FF0, 32'd3, 32'd3, 32'hFFFFFFFE, 32'd6, 32'd2};
    logic [31:0] t_e  [0:13] = '{32'd15, 32'hFFFFFFFF, 32'd1, 32'h80000000, 32'hFFFFFFFE, 32'h00F0, 32'hFFF0,
                                 32'hFF00, 32'hFFFF000F, 32'd1, 32'd0, 32'd0, 32'd0, 32'd3};

    task automatic test_alu();
        id_ex_valid = 1'b1;
        alu_op = 2'b10; funct = 6'h22; alu_src = 1'b0;
        forward_a = 2'b10; forward_b = 2'b00;
        mem_result = 32'd20; read_data1 = 32'd5; read_data2 = 32'd9;
        #1;
        vec_cnt++; if (alu_result !== 32'd11) begin err_cnt++; $display("FAIL fwd_mem_sub: got %h expected 0000000b", alu_result); end
        vec_cnt++; if (zero !== 1'b0) begin err_cnt++; $display("FAIL fwd_mem_zero: got %b expected 0", zero); end
        forward_a = 2'b00; read_data1 = 32'd9;
        #1;
        vec_cnt++; if (alu_result !== 32'd0) begin err_cnt++; $display("FAIL rf_sub: got %h expected 00000000", alu_result); end
        vec_cnt++; if (zero !== 1'b1) begin err_cnt++; $display("FAIL rf_sub_zero: got %b expected 1", zero); end

        for (int i = 0; i < 14; i++) begin
            alu_op = t_op[i]; funct = t_fn[i];
            read_data1 = t_a[i]; read_data2 = t_b[i];
            #1;
            vec_cnt++;
            if (alu_result !== t_e[i] || zero !== (t_e[i] == 32'd0)) begin
                err_cnt++;
                $display("FAIL alu_vec%0d: got %h zero=%b expected %h", i, alu_result, zero, t_e[i]);
            end
        end

        alu_op = 2'b00; alu_src = 1'b1; read_data1 = 32'd100; imm = 32'hFFFFFFFC;
        read_data2 = 32'hABCD; pc_add4 = 32'h1000; rt = 5'd3; rd = 5'd17; reg_dst = 1'b1;
        #1;
        vec_cnt++; if (alu_result !== 32'd96) begin err_cnt++; $display("FAIL imm_add: got %h expected 00000060", alu_result); end
        vec_cnt++; if (branch_addr !== 32'h00000FF0) begin err_cnt++; $display("FAIL branch_addr: got %h expected 00000ff0", branch_addr); end
        vec_cnt++; if (store_data !== 32'hABCD) begin err_cnt++; $display("FAIL store_rf: got %h expected 0000abcd", store_data); end
        vec_cnt++; if (reg_dest !== 5'd17) begin err_cnt++; $display("FAIL reg_dest_rd: got %0d expected 17", reg_dest); end
        forward_b = 2'b01; wb_result = 32'h55; reg_dst = 1'b0;
        #1;
        vec_cnt++; if (store_data !== 32'h55) begin err_cnt++; $display("FAIL store_wb: got %h expected 00000055", store_data); end
        vec_cnt++; if (reg_dest !== 5'd3) begin err_cnt++; $display("FAIL reg_dest_rt: got %0d expected 3", reg_dest); end
        forward_b = 2'b10; mem_result = 32'h77;
        #1;
        vec_cnt++; if (store_data !== 32'h77) begin err_cnt++; $display("FAIL store_mem: got %h expected 00000077", store_data); end
        vec_cnt++; if (alu_result !== 32'd96) begin err_cnt++; $display("FAIL imm_ignores_fwd_b: got %h expected 00000060", alu_result); end
        forward_b = 2'b00; alu_src = 1'b0; id_ex_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_mult();
        int cyc;
        run_mdu(6'h18, 32'hFFFFFFFD, 32'd7, cyc);
        vec_cnt++; if (cyc != STALL_M7) begin err_cnt++; $display("FAIL mult_stall: got %0d expected %0d", cyc, STALL_M7); end
        vec_cnt++; if (hi !== 32'hFFFFFFFF) begin err_cnt++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        vec_cnt++; if (lo !== 32'hFFFFFFEB) begin err_cnt++; $display("FAIL mult_lo: got %h expected ffffffeb", lo); end
        id_ex_valid = 1'b1; alu_op = 2'b10; funct = 6'h12;
        #1;
        vec_cnt++; if (alu_result !== 32'hFFFFFFEB) begin err_cnt++; $display("FAIL mflo: got %h expected ffffffeb", alu_result); end
        vec_cnt++; if (ex_stall !== 1'b0) begin err_cnt++; $display("FAIL mflo_stall: got %b expected 0", ex_stall); end
        next_cycle();
        id_ex_valid = 1'b0;
    endtask

    task automatic test_div();
        int cyc;
        run_mdu(6'h1A, 32'hFFFFFFF9, 32'd2, cyc);
        vec_cnt++; if (cyc != STALL_FULL) begin err_cnt++; $display("FAIL div_stall: got %0d expected 33", cyc); end
        vec_cnt++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin err_cnt++; $display("FAIL div_neg7_2: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", hi, lo); end
        run_mdu(6'h1A, 32'd7, 32'hFFFFFFFE, cyc);
        vec_cnt++; if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin err_cnt++; $display("FAIL div_7_neg2: got hi=%h lo=%h expected hi=00000001 lo=fffffffd", hi, lo); end
        run_mdu(6'h1B, 32'd9, 32'd0, cyc);
        vec_cnt++; if (cyc != STALL_FULL) begin err_cnt++; $display("FAIL divu0_stall: got %0d expected 33", cyc); end
        vec_cnt++; if (hi !== 32'd9 || lo !== 32'hFFFFFFFF) begin err_cnt++; $display("FAIL divu_by0: got hi=%h lo=%h expected hi=00000009 lo=ffffffff", hi, lo); end
        run_mdu(6'h1A, 32'hFFFFFFF9, 32'd0, cyc);
        vec_cnt++; if (hi !== 32'hFFFFFFF9 || lo !== 32'hFFFFFFFF) begin err_cnt++; $display("FAIL div_by0: got hi=%h lo=%h expected hi=fffffff9 lo=ffffffff", hi, lo); end
        run_mdu(6'h1A, 32'h80000000, 32'hFFFFFFFF, cyc);
        vec_cnt++; if (hi !== 32'd0 || lo !== 32'h80000000) begin err_cnt++; $display("FAIL div_minneg: got hi=%h lo=%h expected hi=00000000 lo=80000000", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_mdu(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        vec_cnt++; if (cyc != STALL_FULL) begin err_cnt++; $display("FAIL multu_max_stall: got %0d expected 33", cyc); end
        vec_cnt++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin err_cnt++; $display("FAIL multu_max: got hi=%h lo=%h expected hi=fffffffe lo=00000001", hi, lo); end
        run_mdu(6'h1B, 32'd100, 32'd7, cyc);
        vec_cnt++; if (cyc != STALL_FULL) begin err_cnt++; $display("FAIL b2b_divu_stall: got %0d expected 33", cyc); end
        vec_cnt++; if (hi !== 32'd2 || lo !== 32'd14) begin err_cnt++; $display("FAIL b2b_divu: got hi=%h lo=%h expected hi=00000002 lo=0000000e", hi, lo); end
    endtask

    task automatic test_mthi_bubble();
        id_ex_valid = 1'b1; alu_op = 2'b10; funct = 6'h11;
        forward_a = 2'b01; wb_result = 32'h1234; read_data1 = 32'h9999;
        next_cycle();
        funct = 6'h13; forward_a = 2'b10; mem_result = 32'h5678;
        next_cycle();
        funct = 6'h10; forward_a = 2'b00;
        #1;
        vec_cnt++; if (alu_result !== 32'h1234) begin err_cnt++; $display("FAIL mfhi_after_mthi: got %h expected 00001234", alu_result); end
        vec_cnt++; if (lo !== 32'h5678) begin err_cnt++; $display("FAIL mtlo: got %h expected 00005678", lo); end
        next_cycle();
        id_ex_valid = 1'b0; funct = 6'h11; read_data1 = 32'hDEAD;
        next_cycle();
        funct = 6'h18; read_data2 = 32'd3;
        #1;
        vec_cnt++; if (ex_stall !== 1'b0) begin err_cnt++; $display("FAIL bubble_no_stall: got %b expected 0", ex_stall); end
        next_cycle();
        next_cycle();
        vec_cnt++; if (hi !== 32'h1234 || lo !== 32'h5678) begin err_cnt++; $display("FAIL bubble_hilo: got hi=%h lo=%h expected hi=00001234 lo=00005678", hi, lo); end
        funct = 6'h00;
    endtask

    task automatic test_reset_midop();
        id_ex_valid = 1'b1; alu_op = 2'b10; funct = 6'h19;
        forward_a = 2'b00; forward_b = 2'b00;
        read_data1 = 32'd12345; read_data2 = 32'hFFFFFFFF;
        #1;
        repeat (9) next_cycle();
        vec_cnt++; if (ex_stall !== 1'b1) begin err_cnt++; $display("FAIL midop_stall10: got %b expected 1", ex_stall); end
        reset = 1'b1; id_ex_valid = 1'b0;
        next_cycle();
        vec_cnt++; if (ex_stall !== 1'b0) begin err_cnt++; $display("FAIL midop_reset_stall: got %b expected 0", ex_stall); end
        vec_cnt++; if (hi !== 32'd0 || lo !== 32'd0) begin err_cnt++; $display("FAIL midop_reset_hilo: got hi=%h lo=%h expected 0", hi, lo); end
        reset = 1'b0; id_ex_valid = 1'b1; funct = 6'h10;
        #1;
        vec_cnt++; if (alu_result !== 32'd0 || ex_stall !== 1'b0) begin err_cnt++; $display("FAIL mfhi_after_reset: got %h stall=%b expected 00000000 stall=0", alu_result, ex_stall); end
        next_cycle();
        id_ex_valid = 1'b0;
    endtask

    task automatic test_early_term();
        int cyc;
        run_mdu(6'h19, 32'd5, 32'd3, cyc);
        vec_cnt++; if (cyc != STALL_M3) begin err_cnt++; $display("FAIL multu_b3_stall: got %0d expected %0d", cyc, STALL_M3); end
        vec_cnt++; if (hi !== 32'd0 || lo !== 32'd15) begin err_cnt++; $display("FAIL multu_5x3: got hi=%h lo=%h expected hi=00000000 lo=0000000f", hi, lo); end
        run_mdu(6'h19, 32'hCAFE, 32'd0, cyc);
        vec_cnt++; if (cyc != STALL_M0) begin err_cnt++; $display("FAIL multu_b0_stall: got %0d expected %0d", cyc, STALL_M0); end
        vec_cnt++; if (hi !== 32'd0 || lo !== 32'd0) begin err_cnt++; $display("FAIL multu_x0: got hi=%h lo=%h expected 0", hi, lo); end
        run_mdu(6'h1B, 32'd5, 32'd3, cyc);
        vec_cnt++; if (cyc != STALL_FULL) begin err_cnt++; $display("FAIL divu_small_stall: got %0d expected 33", cyc); end
        vec_cnt++; if (hi !== 32'd2 || lo !== 32'd1) begin err_cnt++; $display("FAIL divu_5_3: got hi=%h lo=%h expected hi=00000002 lo=00000001", hi, lo); end
    endtask

    initial begin
        reset = 1'b1; id_ex_valid = 1'b0; pc_add4 = '0; read_data1 = '0; read_data2 = '0;
        imm = '0; rt = '0; rd = '0; funct = '0; alu_op = '0; alu_src = 1'b0; reg_dst = 1'b0;
        mem_result = '0; wb_result = '0; forward_a = '0; forward_b = '0;
        test_reset();
        test_alu();
        test_mult();
        test_div();
        test_back_to_back();
        test_mthi_bubble();
        test_reset_midop();
        test_early_term();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
